// File: rtl/soric_gpio_ctrl.sv
// soric_gpio_ctrl: pad-side control/status stage (io_in filter, core start sequencer, Wishbone checkpoint).
// Optional sticky run-state interrupt is built when SORIC_GPIO_CTRL_IRQ_EN is defined.
module soric_gpio_ctrl #(
  parameter int          SYNC_STAGES = 2,
  parameter int          DEB_CYCLES  = 16,
  parameter int          RST_CYCLES  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [7:0]  io_in,
  output logic [15:0] io_out,
  output logic [23:0] io_oeb,
  output logic        core_rst_no,
  output logic        fetch_en_o,
  output logic        irq_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  // state | meaning: IDLE core held in reset | RST_HOLD reset countdown | RUN core fetching
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2
  } state_e;

  logic [7:0]    sync_q [SYNC_STAGES];
  logic [7:0]    sync_v;
  logic [7:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    ctrl_q;
  logic          run_prev_q;

  state_e        state_q;
  logic [RW-1:0] rcnt_q;
  logic          core_rst_q;
  logic          fetch_q;

  logic          run;
  logic          en_ok;
  logic          keep;
  logic          start;
  logic          start_acc;

  logic          ack_q;
  logic [31:0]   dat_q;
  logic [15:0]   ckpt_q;
  logic [15:0]   io_out_q;
  logic [15:0]   start_cnt_q;

  logic          wb_sel;
  logic          wb_wr;
  logic [1:0]    reg_idx;
  logic          wr_ckpt;
  logic          wr_cnt;
  logic [1:0]    state_bits;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_v = sync_q[SYNC_STAGES-1];

  // cnt holds at its terminal value once stable, so ctrl_q keeps reloading the same value
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cand_q <= '0;
      cnt_q  <= '0;
      ctrl_q <= '0;
    end else if (sync_v != cand_q) begin
      cand_q <= sync_v;
      cnt_q  <= '0;
    end else if (cnt_q == DEB_LAST) begin
      ctrl_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) run_prev_q <= 1'b0;
    else            run_prev_q <= ctrl_q[5];
  end

  assign run       = ctrl_q[5];
  assign en_ok     = (ctrl_q[2:1] == 2'b11);
  assign keep      = run & en_ok;
  assign start     = run & ~run_prev_q & en_ok;
  assign start_acc = start & (state_q == S_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      rcnt_q     <= '0;
      core_rst_q <= 1'b0;
      fetch_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RST_HOLD;
            rcnt_q  <= '0;
          end
        end
        S_RST_HOLD: begin
          if (!keep) begin
            state_q <= S_IDLE;
          end else if (rcnt_q == RST_LAST) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b1;
            fetch_q    <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!keep) begin
            state_q    <= S_IDLE;
            core_rst_q <= 1'b0;
            fetch_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= 1'b0;
          fetch_q    <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_no = core_rst_q;
  assign fetch_en_o  = fetch_q;
  assign state_bits  = state_q;

  assign wb_sel  = wbs_cyc_i & wbs_stb_i & ~ack_q & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_wr   = wb_sel & wbs_we_i;
  assign reg_idx = wbs_adr_i[3:2];
  assign wr_ckpt = wb_wr & (reg_idx == 2'd0);
  assign wr_cnt  = wb_wr & (reg_idx == 2'd2);

`ifdef SORIC_GPIO_CTRL_IRQ_EN
  logic irq_q;
  logic wr_status;
  logic enter_run;
  logic leave_run;

  assign wr_status = wb_wr & (reg_idx == 2'd1);
  assign enter_run = (state_q == S_RST_HOLD) & keep & (rcnt_q == RST_LAST);
  assign leave_run = (state_q == S_RUN) & ~keep;

  // a set in the same cycle as a clear wins
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= (irq_q & ~wr_status) | enter_run | leave_run;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0:    rdata = {16'h0000, ckpt_q};
      2'd1:    rdata = {21'h0, irq_o, state_bits, ctrl_q};
      2'd2:    rdata = {16'h0000, start_cnt_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= wb_sel;
      dat_q <= (wb_sel & ~wbs_we_i) ? rdata : 32'h0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ckpt_q   <= '0;
      io_out_q <= '0;
    end else begin
      if (wr_ckpt && wbs_sel_i[0]) ckpt_q[7:0]  <= wbs_dat_i[7:0];
      if (wr_ckpt && wbs_sel_i[1]) ckpt_q[15:8] <= wbs_dat_i[15:8];
      io_out_q <= ckpt_q;
    end
  end

  assign io_out = io_out_q;
  assign io_oeb = {16'h0000, 8'hFF};

  // a clear that lands on the same edge as a start leaves exactly that start counted
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      start_cnt_q <= '0;
    end else if (wr_cnt) begin
      start_cnt_q <= {15'h0000, start_acc};
    end else if (start_acc && (start_cnt_q != 16'hFFFF)) begin
      start_cnt_q <= start_cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/soric_gpio_ctrl.md
Name: soric_gpio_ctrl

Overview:
- Pad-side control and status stage of the soric user project.
- Sits between the Caravel mprj_io pins and the ibex cores.
- Input path: host control bits on io_in[7:0] are synchronized, debounced and decoded into a core reset/fetch-enable sequence.
- Output path: a Wishbone-writable 16-bit checkpoint register drives io_out[31:16] so the firmware can report progress codes to the outside world.

Parameters:
SYNC_STAGES, 2, synchronizer flops on io_in[7:0] (min 2)
DEB_CYCLES, 16, consecutive identical synchronized samples required before the filtered control value updates (min 1)
RST_CYCLES, 8, cycles the core reset stays asserted after a start request (min 1)
BASE_ADDR, 32'h3000_0000, Wishbone base address; register window is 16 bytes

Ports:
wb_clk_i  in  1  single clock for the whole block
wb_rst_ni  in  1  synchronous, active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  8  host control bits from mprj_io[7:0]
io_out  out  16  checkpoint value to mprj_io[31:16]
io_oeb  out  24  output enables, active low: [23:8] for pins 31:16, [7:0] for pins 7:0
core_rst_no  out  1  ibex reset, active low
fetch_en_o  out  1  ibex fetch enable
irq_o  out  1  interrupt, see Optional Feature

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous, active-low on wb_rst_ni.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0
  - io_out=0; checkpoint=0
  - core_rst_no=0, fetch_en_o=0, irq_o=0
  - sync chain, candidate, counter and ctrl_q all 0; start_cnt=0; FSM=IDLE
- io_oeb is constant: bits [23:8]=0 (driven), bits [7:0]=1 (input).
- Input filter:
  - io_in passes through SYNC_STAGES flops to give sync_v.
  - If sync_v != candidate: candidate<=sync_v and cnt<=0.
  - Else if cnt==DEB_CYCLES-1: ctrl_q<=candidate.
  - Else: cnt<=cnt+1.
  - A pad change held stable updates ctrl_q exactly SYNC_STAGES+DEB_CYCLES+1 cycles later.
  - A glitch shorter than DEB_CYCLES never reaches ctrl_q.
- Decode:
  - run = ctrl_q[5]; enables = ctrl_q[2:1].
  - start = rising edge of run (ctrl_q[5] & ~ctrl_q_d[5]) while enables==2'b11.
  - A rising edge of run with enables != 2'b11 is ignored. It is not retried later, even if enables become valid while run stays high.
- FSM:
  - IDLE: core_rst_no=0, fetch_en_o=0. On start go to RST_HOLD, load rcnt=0, and increment start_cnt (16-bit, saturates at 16'hFFFF).
  - RST_HOLD: core_rst_no=0, fetch_en_o=0. rcnt increments each cycle; when rcnt==RST_CYCLES-1 go to RUN.
  - RUN: core_rst_no=1, fetch_en_o=1.
  - In RST_HOLD or RUN, if run==0 or enables!=2'b11, go to IDLE on the next edge; outputs drop in that cycle.
  - Outputs are registered Moore outputs, so fetch_en_o rises exactly RST_CYCLES+1 cycles after start.
- Wishbone:
  - Selected when cyc&stb, ~ack, and adr[31:4]==BASE_ADDR[31:4].
  - wbs_ack_o pulses high for exactly one cycle, the cycle after select. Back-to-back accesses therefore take 2 cycles each.
  - Unselected addresses never ack.
  - Register map:
    - 0x0 CHECKPOINT: RW [15:0]. Honour wbs_sel_i[1:0] per byte; bits [31:16] read 0.
    - 0x4 STATUS: RO. {22'b0, state[1:0] at [9:8], ctrl_q[7:0]}. Encoding IDLE=0, RST_HOLD=1, RUN=2.
    - 0x8 START_CNT: [15:0]. Any write clears it to 0. If a write coincides with a start, the count becomes 1.
    - 0xC: reads 0, writes ignored, still acked.
  - Read data is valid with ack; wbs_dat_o=0 when not acking.
- io_out tracks checkpoint one cycle after the write ack edge.
- Reset mid-operation: everything returns to reset values on the next edge, including a pending ack, which is dropped.

Optional Feature:
- Macro: SORIC_GPIO_CTRL_IRQ_EN.
- Defined:
  - irq_o is a sticky level, set on the cycle the FSM enters RUN.
  - Also set when the FSM leaves RUN for IDLE.
  - Cleared by any Wishbone write to STATUS (0x4). A set and a clear in the same cycle leave it set.
  - STATUS bit [10] reads irq_o.
- Not defined: irq_o tied to 0 and STATUS[10] reads 0.

Test Plan:
- Reset then idle: io_in=8'h06 stable -> ctrl_q=8'h06 after SYNC_STAGES+DEB_CYCLES+1 cycles; STATUS reads 0x006; core_rst_no=0, fetch_en_o=0.
- Start sequence: io_in 8'h06 -> 8'h26 -> core_rst_no=0 held for 8 cycles in RST_HOLD, then core_rst_no=1 and fetch_en_o=1; START_CNT=1; STATUS=0x226.
- Glitch rejection: io_in pulses 8'h26 for 10 cycles then returns to 8'h06 (DEB_CYCLES=16) -> ctrl_q and FSM stay unchanged; START_CNT=0.
- Bad enables: io_in=8'h20 (enables 00) -> FSM stays IDLE. Then io_in=8'h06 in RUN -> FSM goes to IDLE and fetch_en_o=0 next cycle.
- Checkpoint: write 0x0003 to BASE+0 with sel=4'b0011 -> ack 1 cycle later, io_out=16'h0003. Write 0xFF05 with sel=4'b0001 -> io_out=16'h0005. Read BASE+0 returns 0x00000005.
- IRQ (macro defined): enter RUN -> irq_o=1; write STATUS -> irq_o=0 next cycle; drop run -> irq_o=1 again. Macro undefined -> irq_o stays 0 throughout.
